// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers and threshold legality checks shared by the FIFO family
package fifo_pkg;
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
  function automatic int fifoDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction
  function automatic bit fullThreshLegal(input int thresh, input int depth);
    return thresh >= 1 && thresh <= depth;
  endfunction
  function automatic bit emptyThreshLegal(input int thresh, input int depth);
    return thresh >= 0 && thresh <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: single write port, asynchronous read port storage, never reset
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int dataWidth = 8,
  parameter int addrWidth = 3
) (
  input  logic                 clkIn,
  input  logic                 writeEnableIn,
  input  logic [addrWidth-1:0] writeAddrIn,
  input  logic [dataWidth-1:0] writeDataIn,
  input  logic [addrWidth-1:0] readAddrIn,
  output logic [dataWidth-1:0] readDataOut
);
  logic [dataWidth-1:0] mem [fifoDepth(addrWidth)];
  always_ff @(posedge clkIn)
    if (writeEnableIn) mem[writeAddrIn] <= writeDataIn;
  assign readDataOut = mem[readAddrIn];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with almost-full/empty thresholds, fill count and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dataOut is registered.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int dataWidth         = 8,
  parameter int addrWidth         = 3,
  parameter int almostFullThresh  = (1 << addrWidth) - 2,
  parameter int almostEmptyThresh = 2
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [dataWidth-1:0] dataIn,
  input  logic                 writeEnableIn,
  input  logic                 readEnableIn,
  output logic [dataWidth-1:0] dataOut,
  output logic                 fifoFullOut,
  output logic                 fifoEmptyOut,
  output logic                 almostFullOut,
  output logic                 almostEmptyOut,
  output logic [addrWidth:0]   fillCountOut,
  output logic                 overflowOut,
  output logic                 underflowOut
);
  localparam int depth = fifoDepth(addrWidth);
  localparam logic [addrWidth:0] depthCount = depth[addrWidth:0];
  localparam logic [addrWidth:0] afCount = almostFullThresh[addrWidth:0];
  localparam logic [addrWidth:0] aeCount = almostEmptyThresh[addrWidth:0];
  if (!fullThreshLegal(almostFullThresh, depth) || !emptyThreshLegal(almostEmptyThresh, depth)) begin : gBadThresh
    $error("sync_fifo_flags: almost-full/almost-empty threshold out of range");
  end
  logic [addrWidth-1:0] wrPtr, rdPtr;
  logic [addrWidth:0]   count;
  logic [dataWidth-1:0] ramRd;
  logic                 wrAcc, rdAcc;
  assign fifoFullOut    = count == depthCount;
  assign fifoEmptyOut   = count == '0;
  assign almostFullOut  = count >= afCount;
  assign almostEmptyOut = count <= aeCount;
  assign fillCountOut   = count;
  // acceptance sees only pre-edge flags, so a read never makes room for a same-cycle write
  assign wrAcc = writeEnableIn && !fifoFullOut;
  assign rdAcc = readEnableIn && !fifoEmptyOut;
  fifo_ram #(.dataWidth(dataWidth), .addrWidth(addrWidth)) uRam (
    .clkIn        (clkIn),
    .writeEnableIn(wrAcc),
    .writeAddrIn  (wrPtr),
    .writeDataIn  (dataIn),
    .readAddrIn   (rdPtr),
    .readDataOut  (ramRd)
  );
  always_ff @(posedge clkIn or posedge rstIn)
    if (rstIn) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      overflowOut  <= 1'b0;
      underflowOut <= 1'b0;
    end else begin
      wrPtr        <= wrPtr + addrWidth'(wrAcc);
      rdPtr        <= rdPtr + addrWidth'(rdAcc);
      count        <= count + (addrWidth+1)'(wrAcc) - (addrWidth+1)'(rdAcc);
      overflowOut  <= writeEnableIn && fifoFullOut;
      underflowOut <= readEnableIn && fifoEmptyOut;
    end
`ifdef FIFO_FWFT_EN
  assign dataOut = fifoEmptyOut ? '0 : ramRd;
`else
  always_ff @(posedge clkIn or posedge rstIn)
    if (rstIn) dataOut <= '0;
    else if (rdAcc) dataOut <= ramRd;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed and randomized checks of sync_fifo_flags against a queue model
module tb_sync_fifo_flags;
  localparam int depth = 8;
  localparam int afThresh = 6;
  localparam int aeThresh = 2;
  logic       clkIn = 1'b0, rstIn = 1'b1, writeEnableIn = 1'b0, readEnableIn = 1'b0;
  logic [7:0] dataIn = 8'h0, dataOut;
  logic       fifoFullOut, fifoEmptyOut, almostFullOut, almostEmptyOut, overflowOut, underflowOut;
  logic [3:0] fillCountOut;
  int         checks = 0, errors = 0;
  logic [7:0] model[$];
  logic [7:0] expData = 8'h0;
  logic       expOv = 1'b0, expUn = 1'b0;

  sync_fifo_flags dut (
    .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .writeEnableIn(writeEnableIn),
    .readEnableIn(readEnableIn), .dataOut(dataOut), .fifoFullOut(fifoFullOut),
    .fifoEmptyOut(fifoEmptyOut), .almostFullOut(almostFullOut), .almostEmptyOut(almostEmptyOut),
    .fillCountOut(fillCountOut), .overflowOut(overflowOut), .underflowOut(underflowOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int n;
    n = model.size();
    check("count", fillCountOut, n);
    check("full", fifoFullOut, n == depth);
    check("empty", fifoEmptyOut, n == 0);
    check("almostFull", almostFullOut, n >= afThresh);
    check("almostEmpty", almostEmptyOut, n <= aeThresh);
    check("overflow", overflowOut, expOv);
    check("underflow", underflowOut, expUn);
`ifdef FIFO_FWFT_EN
    check("data", dataOut, n != 0 ? model[0] : 8'h0);
`else
    check("data", dataOut, expData);
`endif
  endtask

  task automatic modelReset();
    model.delete();
    expData = 8'h0;
    expOv = 1'b0;
    expUn = 1'b0;
  endtask

  // drive one cycle of requests, advance the model by the same rules, then check
  task automatic cycle(input logic we, input logic re, input logic [7:0] d);
    bit full, empty;
    writeEnableIn = we;
    readEnableIn = re;
    dataIn = d;
    @(posedge clkIn);
    full = model.size() == depth;
    empty = model.size() == 0;
    expOv = we && full;
    expUn = re && empty;
    if (re && !empty) expData = model.pop_front();
    if (we && !full) model.push_back(d);
    #1 checkAll();
  endtask

  initial begin
    #2 checkAll();
    #10 rstIn = 1'b0;
    @(posedge clkIn);
    #1 checkAll();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'h99);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'h20 + 8'(i));
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 8'h78);
    check("countBeforeReset", fillCountOut, 5);
    writeEnableIn = 1'b1;
    dataIn = 8'hEE;
    #3 rstIn = 1'b1;
    modelReset();
    #1 checkAll();
    @(posedge clkIn);
    #1 checkAll();
    rstIn = 1'b0;
    writeEnableIn = 1'b0;
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);
    check("postResetData", expData, 8'h3C);
`ifdef FIFO_FWFT_EN
    cycle(1'b1, 1'b0, 8'hA5);
    check("fwftA5", dataOut, 8'hA5);
    cycle(1'b0, 1'b1, 8'h00);
`endif
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2) ? 30 : 70;
      cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias, 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
